// File: rtl/param_univ_shift_reg.sv
// Universal shift register (hold / shift left / shift right / load) with a per-word shift
// counter and a one-cycle completion pulse. Parallel load is built only with UNIV_SHIFT_PLOAD_EN.
module param_univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     data_in,
    input  logic [WIDTH-1:0]         pdata_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     serial_out,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     word_valid
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             valid_reg;
    logic             valid_next;
    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] shr_vec;

    // Per-bit neighbour selection; the serial input enters at the LSB (left) or MSB (right).
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (gi == 0) begin : g_lsb
            assign shl_vec[gi] = data_in;
        end else begin : g_shl
            assign shl_vec[gi] = data_reg[gi-1];
        end
        if (gi == WIDTH - 1) begin : g_msb
            assign shr_vec[gi] = data_in;
        end else begin : g_shr
            assign shr_vec[gi] = data_reg[gi+1];
        end
    end

`ifndef UNIV_SHIFT_PLOAD_EN
    logic [WIDTH-1:0] pdata_unused;
    assign pdata_unused = pdata_in;
`endif

    always_comb begin
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        valid_next = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHL, MODE_SHR: begin
                    data_next = (mode == MODE_SHL) ? shl_vec : shr_vec;
                    // Direction changes keep counting; the wrap marks a completed word.
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        valid_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                MODE_LOAD: begin
`ifdef UNIV_SHIFT_PLOAD_EN
                    data_next = pdata_in;
                    cnt_next  = '0;
`endif
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg  <= RST_VAL;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
        end
    end

    assign data_out   = data_reg;
    assign bit_cnt    = cnt_reg;
    assign word_valid = valid_reg;
    assign serial_out = (mode == MODE_SHL) ? data_reg[WIDTH-1] : data_reg[0];

endmodule

// File: tb/tb_param_univ_shift_reg.sv
// Table-driven bench for param_univ_shift_reg (WIDTH=8); expected values are hand-derived,
// queued when a vector is driven and compared after the following rising edge.
module tb_param_univ_shift_reg;

`ifdef UNIV_SHIFT_PLOAD_EN
    localparam bit PLOAD = 1'b1;
`else
    localparam bit PLOAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       data_in = 1'b0;
    logic [7:0] pdata_in = 8'h00;
    logic [7:0] data_out, data_out_5a;
    logic       serial_out, serial_out_5a;
    logic [2:0] bit_cnt, bit_cnt_5a;
    logic       word_valid, word_valid_5a;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    param_univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .data_in(data_in),
        .pdata_in(pdata_in), .data_out(data_out), .serial_out(serial_out),
        .bit_cnt(bit_cnt), .word_valid(word_valid)
    );

    param_univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h5A)) dut_5a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .data_in(data_in),
        .pdata_in(pdata_in), .data_out(data_out_5a), .serial_out(serial_out_5a),
        .bit_cnt(bit_cnt_5a), .word_valid(word_valid_5a)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] mode;
        logic       din;
        logic [7:0] pdata;
        logic [7:0] exp_data;
        logic [2:0] exp_cnt;
        logic       exp_valid;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] cnt;
        logic       valid;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic void add(input logic r, input logic e, input logic [1:0] m,
                                input logic d, input logic [7:0] p, input logic [7:0] xd,
                                input logic [2:0] xc, input logic xv);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.din = d; v.pdata = p;
        v.exp_data = xd; v.exp_cnt = xc; v.exp_valid = xv;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    initial begin
        exp_t       e;
        logic [7:0] prev;
        logic       prev_known;
        logic       exp_sout;
        int         pulses;

        // reset, with en/mode active to show reset priority
        add(0,1,2'b01,1,8'h00, 8'h00,0,0);
        add(0,1,2'b01,1,8'h00, 8'h00,0,0);
        // shift left 1,1,0,0,0,0,0,0
        add(1,1,2'b01,1,8'h00, 8'h01,1,0);
        add(1,1,2'b01,1,8'h00, 8'h03,2,0);
        add(1,1,2'b01,0,8'h00, 8'h06,3,0);
        add(1,1,2'b01,0,8'h00, 8'h0C,4,0);
        add(1,1,2'b01,0,8'h00, 8'h18,5,0);
        add(1,1,2'b01,0,8'h00, 8'h30,6,0);
        add(1,1,2'b01,0,8'h00, 8'h60,7,0);
        add(1,1,2'b01,0,8'h00, 8'hC0,0,1);
        add(1,1,2'b00,1,8'h00, 8'hC0,0,0);
        // shift right, same bits
        add(1,1,2'b10,1,8'h00, 8'hE0,1,0);
        add(1,1,2'b10,1,8'h00, 8'hF0,2,0);
        add(1,1,2'b10,0,8'h00, 8'h78,3,0);
        add(1,1,2'b10,0,8'h00, 8'h3C,4,0);
        add(1,1,2'b10,0,8'h00, 8'h1E,5,0);
        add(1,1,2'b10,0,8'h00, 8'h0F,6,0);
        add(1,1,2'b10,0,8'h00, 8'h07,7,0);
        add(1,1,2'b10,0,8'h00, 8'h03,0,1);
        add(1,0,2'b10,1,8'h00, 8'h03,0,0);
        // three shifts, parallel load, then one left shift of a 0
        add(1,1,2'b01,1,8'h00, 8'h07,1,0);
        add(1,1,2'b01,1,8'h00, 8'h0F,2,0);
        add(1,1,2'b01,1,8'h00, 8'h1F,3,0);
        add(1,1,2'b11,1,8'hA5, PLOAD ? 8'hA5 : 8'h1F, PLOAD ? 3'd0 : 3'd3, 0);
        add(1,1,2'b01,0,8'h00, PLOAD ? 8'h4A : 8'h3E, PLOAD ? 3'd1 : 3'd4, 0);
        add(0,1,2'b11,1,8'hFF, 8'h00,0,0);
        // enable gap
        add(1,1,2'b01,1,8'h00, 8'h01,1,0);
        add(1,1,2'b01,1,8'h00, 8'h03,2,0);
        add(1,1,2'b01,1,8'h00, 8'h07,3,0);
        add(1,1,2'b01,1,8'h00, 8'h0F,4,0);
        for (int i = 0; i < 4; i++) add(1,0,2'b01,0,8'h00, 8'h0F,4,0);
        add(1,1,2'b01,0,8'h00, 8'h1E,5,0);
        add(1,1,2'b01,0,8'h00, 8'h3C,6,0);
        add(1,1,2'b01,0,8'h00, 8'h78,7,0);
        add(1,1,2'b01,0,8'h00, 8'hF0,0,1);
        add(1,1,2'b00,0,8'h00, 8'hF0,0,0);
        // mid-word reset discards the partial word
        add(1,1,2'b01,1,8'h00, 8'hE1,1,0);
        add(1,1,2'b01,1,8'h00, 8'hC3,2,0);
        add(1,1,2'b01,1,8'h00, 8'h87,3,0);
        add(1,1,2'b01,1,8'h00, 8'h0F,4,0);
        add(1,1,2'b01,1,8'h00, 8'h1F,5,0);
        add(0,1,2'b01,1,8'h00, 8'h00,0,0);
        add(1,1,2'b01,1,8'h00, 8'h01,1,0);
        add(1,1,2'b01,1,8'h00, 8'h03,2,0);
        add(1,1,2'b01,1,8'h00, 8'h07,3,0);
        add(1,1,2'b01,1,8'h00, 8'h0F,4,0);
        add(1,1,2'b01,1,8'h00, 8'h1F,5,0);
        add(1,1,2'b01,1,8'h00, 8'h3F,6,0);
        add(1,1,2'b01,1,8'h00, 8'h7F,7,0);
        add(1,1,2'b01,1,8'h00, 8'hFF,0,1);
        add(1,1,2'b00,0,8'h00, 8'hFF,0,0);
        // direction changes mid-word, then a back-to-back word start
        add(1,1,2'b01,0,8'h00, 8'hFE,1,0);
        add(1,1,2'b10,0,8'h00, 8'h7F,2,0);
        add(1,1,2'b01,0,8'h00, 8'hFE,3,0);
        add(1,1,2'b10,1,8'h00, 8'hFF,4,0);
        add(1,1,2'b01,0,8'h00, 8'hFE,5,0);
        add(1,1,2'b01,0,8'h00, 8'hFC,6,0);
        add(1,1,2'b01,0,8'h00, 8'hF8,7,0);
        add(1,1,2'b01,0,8'h00, 8'hF0,0,1);
        add(1,1,2'b01,1,8'h00, 8'hE1,1,0);

        prev = 8'h00;
        prev_known = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; en = vecs[i].en; mode = vecs[i].mode;
            data_in = vecs[i].din; pdata_in = vecs[i].pdata;
            #1;
            if (prev_known) begin
                exp_sout = (vecs[i].mode == 2'b01) ? prev[7] : prev[0];
                chk($sformatf("serial_out[%0d]", i), 64'(serial_out), 64'(exp_sout));
            end
            e.data = vecs[i].exp_data; e.cnt = vecs[i].exp_cnt; e.valid = vecs[i].exp_valid;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            $display("vec %0d: rst_n=%0b en=%0b mode=%0b din=%0b -> data=%02h cnt=%0d valid=%0b",
                     i, vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].din,
                     data_out, bit_cnt, word_valid);
            chk($sformatf("data_out[%0d]", i), 64'(data_out), 64'(e.data));
            chk($sformatf("bit_cnt[%0d]", i), 64'(bit_cnt), 64'(e.cnt));
            chk($sformatf("word_valid[%0d]", i), 64'(word_valid), 64'(e.valid));
            if (!vecs[i].rst_n) begin
                chk($sformatf("rst_val_5a[%0d]", i), 64'(data_out_5a), 64'h5A);
                chk($sformatf("rst_cnt_5a[%0d]", i), 64'(bit_cnt_5a), 64'd0);
            end
            prev = e.data;
            prev_known = 1'b1;
        end

        // Continuous stream of 2*WIDTH+1 shifts after reset: two pulses, counter ends at 1.
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; mode = 2'b10; data_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 17; k++) begin
            data_in = k[0];
            @(posedge clk);
            #1;
            if (word_valid) pulses++;
            @(negedge clk);
        end
        en = 1'b0;
        @(posedge clk);
        #1;
        if (word_valid) pulses++;
        $display("stream: 17 shifts -> pulses=%0d cnt=%0d", pulses, bit_cnt);
        chk("stream_pulses", 64'(pulses), 64'd2);
        chk("stream_cnt", 64'(bit_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
